// File: rtl/cs_controller.sv
// ---------------------------------------------------------------------------
// cs_controller
//
// Harvests entropy from a coherent sampler. The sampler raises req
// (asynchronous to clk) with a stable counter value on cnt. The controller
// captures the LSB of each count into a shift register, and acknowledges the
// sampler so it clears req and restarts. Once OUT_WIDTH bits are assembled,
// the word is offered on data/valid. The sampler is held acknowledged (idle)
// until the consumer takes the word.
//
// Optional feature: define CS_CTRL_HEALTH_EN to build the repetition/zero
// health test that drives a sticky alarm. Without it, alarm is constant 0
// and no comparison logic exists.
//
// Parameters
//   CNT_WIDTH  width of the sampler counter bus
//   OUT_WIDTH  entropy bits per output word (2..32)
//   REP_LIMIT  identical consecutive counts that raise alarm (health test)
//
// Ports
//   clk      in   system clock, rising edge
//   rstN     in   asynchronous active-low reset
//   en       in   1 = harvest, 0 = park the sampler (ack held high)
//   req      in   sampler request, asynchronous, synchronised internally
//   cnt      in   sampler count, stable while req is high
//   ack      out  acknowledge to sampler (registered)
//   data     out  assembled entropy word, first captured bit in the MSB
//   valid    out  data is valid
//   ready    in   consumer accepts data when valid && ready
//   lastCnt  out  last captured raw count
//   alarm    out  sticky health-test failure
// ---------------------------------------------------------------------------
module cs_controller #(
    parameter int CNT_WIDTH = 16,
    parameter int OUT_WIDTH = 8,
    parameter int REP_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 en,
    input  logic                 req,
    input  logic [CNT_WIDTH-1:0] cnt,
    output logic                 ack,
    output logic [OUT_WIDTH-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic [CNT_WIDTH-1:0] lastCnt,
    output logic                 alarm
);

    localparam int BIT_W = $clog2(OUT_WIDTH + 1);

    typedef enum logic [2:0] {
        PARK,
        WAIT_REQ,
        CAPTURE,
        WAIT_REL,
        STALL
    } state_t;

    // -----------------------------------------------------------------------
    // Reset release synchroniser. Assertion is immediate; release ripples
    // through two flops so the FSM cannot move before the second clk edge
    // after rstN rises.
    // -----------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       run;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    // -----------------------------------------------------------------------
    // Two-flop synchroniser for req. Nothing else looks at req directly.
    // -----------------------------------------------------------------------
    logic [1:0] req_sync_q;
    logic       req_s;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            req_sync_q <= 2'b00;
        end else begin
            req_sync_q <= {req_sync_q[0], req};
        end
    end

    assign req_s = req_sync_q[1];

    // -----------------------------------------------------------------------
    // Datapath and FSM registers
    // -----------------------------------------------------------------------
    state_t               state_q, state_d;
    logic                 ack_q, ack_d;
    logic                 valid_q, valid_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0] last_cnt_q, last_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 capture;
    logic                 health_stop;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= PARK;
            ack_q      <= 1'b1;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_cnt_q <= last_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic.
    //
    // The capture itself (lastCnt load, bit shift, bit count) happens on the
    // WAIT_REQ -> CAPTURE transition, so lastCnt updates three edges after
    // req rises. The CAPTURE cycle then decides whether the word is complete.
    //
    // en low (or a raised alarm) overrides only the next state: a word that
    // completes in CAPTURE is still published and its bit count cleared, and
    // partial words simply stay in data_q/bit_cnt_q while parked.
    //
    // ack is registered from the next state, so it falls in the same cycle
    // the FSM enters WAIT_REQ and never has a combinational input path.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        data_d     = data_q;
        last_cnt_d = last_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        capture    = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        if (run) begin
            case (state_q)
                PARK: begin
                    if (en && !valid_q && !health_stop) begin
                        state_d = WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (!req_s) begin
                        state_d = WAIT_REQ;
                    end
                end
                WAIT_REQ: begin
                    if (req_s) begin
                        state_d = CAPTURE;
                        capture = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (bit_cnt_q == BIT_W'(OUT_WIDTH)) begin
                        bit_cnt_d = '0;
                        valid_d   = !health_stop;
                        state_d   = STALL;
                    end else begin
                        state_d = WAIT_REL;
                    end
                end
                STALL: begin
                    if (!valid_q) begin
                        state_d = WAIT_REL;
                    end
                end
                default: begin
                    state_d = PARK;
                end
            endcase

            if (!en || health_stop) begin
                state_d = PARK;
                capture = 1'b0;
            end

            if (capture) begin
                last_cnt_d = cnt;
                data_d     = {data_q[OUT_WIDTH-2:0], cnt[0]};
                bit_cnt_d  = bit_cnt_q + 1'b1;
            end
        end

        ack_d = (state_d != WAIT_REQ) && (state_d != CAPTURE);
    end

`ifdef CS_CTRL_HEALTH_EN
    // -----------------------------------------------------------------------
    // Health test: repetition count of identical consecutive captures, plus
    // a stuck-at-zero check. The repetition counter saturates at REP_LIMIT.
    // -----------------------------------------------------------------------
    localparam int REP_W = $clog2(REP_LIMIT + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             alarm_q, alarm_d;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rep_cnt_q <= '0;
            alarm_q   <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            alarm_q   <= alarm_d;
        end
    end

    // Compare against the previous lastCnt before it is overwritten.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        alarm_d   = alarm_q;
        if (capture) begin
            if (cnt == last_cnt_q) begin
                if (rep_cnt_q != REP_W'(REP_LIMIT)) begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end else begin
                rep_cnt_d = REP_W'(1);
            end
            if ((rep_cnt_d == REP_W'(REP_LIMIT)) || (cnt == '0)) begin
                alarm_d = 1'b1;
            end
        end
    end

    assign health_stop = alarm_q;
    assign alarm       = alarm_q;
`else
    // REP_LIMIT is meaningful only to the health test; the constant-false
    // term keeps it referenced so both builds share one parameter list.
    assign health_stop = 1'b0;
    assign alarm       = (REP_LIMIT < 0);
`endif

    assign ack     = ack_q;
    assign valid   = valid_q;
    assign data    = data_q;
    assign lastCnt = last_cnt_q;

endmodule

// File: tb/tb_cs_controller.sv
// Testbench for cs_controller: table of whole words plus hand sequences for
// latency, backpressure, parking, health test and asynchronous reset.
module tb_cs_controller;

   localparam int CNT_WIDTH = 16;
   localparam int OUT_WIDTH = 8;
   localparam int REP_LIMIT = 4;
   localparam int WAIT_LIMIT = 300;

   logic                 clk;
   logic                 rstN;
   logic                 en;
   logic                 req;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 ack;
   logic [OUT_WIDTH-1:0] data;
   logic                 valid;
   logic                 ready;
   logic [CNT_WIDTH-1:0] lastCnt;
   logic                 alarm;

   int checks = 0;
   int errors = 0;
   int ackRises = 0;
   logic ackPrev;
   logic [CNT_WIDTH-1:0] cntFifo[$];

   typedef struct {
      logic [CNT_WIDTH-1:0] counts [8];
      logic [OUT_WIDTH-1:0] expData;
      logic [CNT_WIDTH-1:0] expLast;
   } vector_t;

   vector_t vectors [5];

   cs_controller #(
      .CNT_WIDTH(CNT_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .REP_LIMIT(REP_LIMIT)
   ) dut (
      .clk(clk),
      .rstN(rstN),
      .en(en),
      .req(req),
      .cnt(cnt),
      .ack(ack),
      .data(data),
      .valid(valid),
      .ready(ready),
      .lastCnt(lastCnt),
      .alarm(alarm)
   );

   // Free-running clock, 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Sampler model: raises req with the next queued count while ack is low,
   // drops req once acknowledged. Acts mid-phase so req is asynchronous to clk.
   initial begin
      req = 1'b0;
      cnt = '0;
      forever begin
         @(negedge clk);
         #2;
         if (req && ack) begin
            req = 1'b0;
         end else if (!req && !ack && rstN && cntFifo.size() > 0) begin
            cnt = cntFifo.pop_front();
            req = 1'b1;
         end
      end
   end

   // Counts rising edges of ack, sampled just after each clock edge
   initial begin
      ackPrev = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ack && !ackPrev) ackRises++;
         ackPrev = ack;
      end
   end

   // Safety net against a stuck run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic pushCount(input logic [CNT_WIDTH-1:0] v);
      cntFifo.push_back(v);
   endtask

   task automatic waitValid(input string name);
      for (int i = 0; i < WAIT_LIMIT; i++) begin
         if (valid === 1'b1) break;
         @(negedge clk);
      end
      checkOutput({name, "_valid"}, 32'(valid), 32'd1);
   endtask

   task automatic waitAckLow(input string name);
      for (int i = 0; i < WAIT_LIMIT; i++) begin
         if (ack === 1'b0) break;
         @(negedge clk);
      end
      checkOutput(name, 32'(ack), 32'd0);
   endtask

   task automatic waitRises(input string name, input int n);
      for (int i = 0; i < WAIT_LIMIT; i++) begin
         if (ackRises >= n) break;
         @(negedge clk);
      end
      checkOutput(name, 32'(ackRises), 32'(n));
   endtask

   // Feeds one table word and checks the published result
   task automatic applyStimulus(input int idx);
      ackRises = 0;
      for (int k = 0; k < 8; k++) pushCount(vectors[idx].counts[k]);
      waitValid($sformatf("vec%0d", idx));
      checkOutput($sformatf("vec%0d_data", idx), 32'(data), 32'(vectors[idx].expData));
      checkOutput($sformatf("vec%0d_last", idx), 32'(lastCnt), 32'(vectors[idx].expLast));
      checkOutput($sformatf("vec%0d_ack_rises", idx), 32'(ackRises), 32'd8);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid_one_cycle", idx), 32'(valid), 32'd0);
   endtask

   initial begin
      int ackOnes;
      int validOnes;
      int dataSame;
      int lastSame;

      vectors[0].counts = '{16'd5, 16'd6, 16'd9, 16'd2, 16'd7, 16'd4, 16'd11, 16'd8};
      vectors[0].expData = 8'hAA;
      vectors[0].expLast = 16'd8;
      vectors[1].counts = '{16'd1, 16'd3, 16'd5, 16'd7, 16'd9, 16'd11, 16'd13, 16'd15};
      vectors[1].expData = 8'hFF;
      vectors[1].expLast = 16'd15;
      vectors[2].counts = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12, 16'd14, 16'd16};
      vectors[2].expData = 8'h00;
      vectors[2].expLast = 16'd16;
      vectors[3].counts = '{16'd3, 16'd2, 16'd2, 16'd5, 16'd4, 16'd1, 16'd6, 16'd9};
      vectors[3].expData = 8'h95;
      vectors[3].expLast = 16'd9;
      vectors[4].counts = '{16'hFFFF, 16'h8001, 16'h8000, 16'h0002,
                            16'h0101, 16'h7FFF, 16'h1000, 16'h0003};
      vectors[4].expData = 8'hCD;
      vectors[4].expLast = 16'h0003;

      rstN  = 1'b0;
      en    = 1'b0;
      ready = 1'b1;

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("rst_ack", 32'(ack), 32'd1);
      checkOutput("rst_valid", 32'(valid), 32'd0);
      checkOutput("rst_data", 32'(data), 32'd0);
      checkOutput("rst_last", 32'(lastCnt), 32'd0);
      checkOutput("rst_alarm", 32'(alarm), 32'd0);

      // Release: no state change before the second edge, so ack still high
      // after three edges (PARK then WAIT_REL at the earliest)
      rstN = 1'b1;
      en   = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("release_ack_held", 32'(ack), 32'd1);
      waitAckLow("release_ack_low");
      @(negedge clk);

      $display("[TB] table vectors");
      for (int v = 0; v < 5; v++) applyStimulus(v);

      // Latency: req rise to lastCnt update is three edges, ack one more
      $display("[TB] latency sequence");
      waitAckLow("lat_pre_ack");
      repeat (4) @(negedge clk);
      ackRises = 0;
      pushCount(16'h00A5);
      for (int i = 0; i < 20; i++) begin
         #1;
         if (req) break;
      end
      checkOutput("lat_req_rose", 32'(req), 32'd1);
      @(posedge clk); #1;
      checkOutput("lat_edge1_last", 32'(lastCnt), 32'h0003);
      @(posedge clk); #1;
      checkOutput("lat_edge2_last", 32'(lastCnt), 32'h0003);
      @(posedge clk); #1;
      checkOutput("lat_edge3_last", 32'(lastCnt), 32'h00A5);
      checkOutput("lat_edge3_ack", 32'(ack), 32'd0);
      @(posedge clk); #1;
      checkOutput("lat_edge4_ack", 32'(ack), 32'd1);
      @(negedge clk);
      for (int k = 1; k <= 7; k++) pushCount(16'(2 * k));
      waitValid("lat_word");
      checkOutput("lat_word_data", 32'(data), 32'h80);
      checkOutput("lat_word_last", 32'(lastCnt), 32'd14);
      @(negedge clk);

      // Backpressure: word held, sampler idle, then resumes
      $display("[TB] backpressure sequence");
      ready = 1'b0;
      pushCount(16'd3); pushCount(16'd5); pushCount(16'd7); pushCount(16'd2);
      pushCount(16'd4); pushCount(16'd6); pushCount(16'd9); pushCount(16'd10);
      for (int k = 1; k <= 8; k++) pushCount(16'(k));
      waitValid("bp_word");
      checkOutput("bp_data", 32'(data), 32'hE2);
      ackOnes = 0; validOnes = 0; dataSame = 0; lastSame = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ack === 1'b1) ackOnes++;
         if (valid === 1'b1) validOnes++;
         if (data === 8'hE2) dataSame++;
         if (lastCnt === 16'd10) lastSame++;
      end
      checkOutput("bp_ack_high", 32'(ackOnes), 32'd50);
      checkOutput("bp_valid_held", 32'(validOnes), 32'd50);
      checkOutput("bp_data_stable", 32'(dataSame), 32'd50);
      checkOutput("bp_no_capture", 32'(lastSame), 32'd50);
      ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_valid_drop", 32'(valid), 32'd0);
      @(negedge clk);
      waitValid("bp_resume");
      checkOutput("bp_resume_data", 32'(data), 32'hAA);
      checkOutput("bp_resume_last", 32'(lastCnt), 32'd8);
      @(negedge clk);

      // Park after three bits; partial word must survive
      $display("[TB] park sequence");
      waitAckLow("park_pre_ack");
      ackRises = 0;
      pushCount(16'd1); pushCount(16'd2); pushCount(16'd3);
      waitRises("park_rises", 3);
      en = 1'b0;
      ackOnes = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack === 1'b1) ackOnes++;
      end
      checkOutput("park_ack_high", 32'(ackOnes), 32'd10);
      checkOutput("park_valid", 32'(valid), 32'd0);
      checkOutput("park_last", 32'(lastCnt), 32'd3);
      en = 1'b1;
      pushCount(16'd5); pushCount(16'd4); pushCount(16'd4); pushCount(16'd7); pushCount(16'd8);
      waitValid("park_word");
      checkOutput("park_word_data", 32'(data), 32'hB2);
      checkOutput("park_word_last", 32'(lastCnt), 32'd8);
      @(negedge clk);

      // Repeated counts
      $display("[TB] health sequence");
      waitAckLow("health_pre_ack");
      ackRises = 0;
      repeat (4) pushCount(16'd7);
      waitRises("health_rises", 4);
      repeat (3) @(negedge clk);
`ifdef CS_CTRL_HEALTH_EN
      checkOutput("health_rep_alarm", 32'(alarm), 32'd1);
      pushCount(16'd9);
      ackOnes = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack === 1'b1) ackOnes++;
      end
      checkOutput("health_parked", 32'(ackOnes), 32'd10);
      checkOutput("health_no_capture", 32'(lastCnt), 32'd7);
      checkOutput("health_no_valid", 32'(valid), 32'd0);
`else
      checkOutput("health_rep_alarm", 32'(alarm), 32'd0);
      pushCount(16'd8); pushCount(16'd9); pushCount(16'd10); pushCount(16'd11);
      waitValid("health_word");
      checkOutput("health_word_data", 32'(data), 32'hF5);
      checkOutput("health_word_last", 32'(lastCnt), 32'd11);
      @(negedge clk);
      waitAckLow("rst_mid_pre_ack");
      repeat (3) @(negedge clk);
`endif

      // Asynchronous reset in the middle of WAIT_REQ, checked before any edge
      $display("[TB] async reset sequence");
      @(posedge clk);
      #3;
      rstN = 1'b0;
      #1;
      checkOutput("arst_ack", 32'(ack), 32'd1);
      checkOutput("arst_valid", 32'(valid), 32'd0);
      checkOutput("arst_data", 32'(data), 32'd0);
      checkOutput("arst_last", 32'(lastCnt), 32'd0);
      checkOutput("arst_alarm", 32'(alarm), 32'd0);
      cntFifo.delete();
      repeat (2) @(negedge clk);
      rstN = 1'b1;

      // Zero count
      $display("[TB] zero count sequence");
      waitAckLow("zero_pre_ack");
      ackRises = 0;
      pushCount(16'd0);
      waitRises("zero_rises", 1);
      repeat (3) @(negedge clk);
`ifdef CS_CTRL_HEALTH_EN
      checkOutput("zero_alarm", 32'(alarm), 32'd1);
      ackOnes = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (ack === 1'b1) ackOnes++;
      end
      checkOutput("zero_parked", 32'(ackOnes), 32'd5);
`else
      checkOutput("zero_alarm", 32'(alarm), 32'd0);
      for (int k = 1; k <= 7; k++) pushCount(16'(k));
      waitValid("zero_word");
      checkOutput("zero_word_data", 32'(data), 32'h55);
      checkOutput("zero_word_last", 32'(lastCnt), 32'd7);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
